// File: rtl/plic_gateway_array.sv
// PLIC gateway array: turns raw async device interrupt lines into per-source
// pending (ip) and lock (in_flight) bits for the fan-in comparator.

module plic_gateway_src #(
   parameter int   SYNC_STAGES = 2,
   parameter bit   IS_EDGE     = 1'b0,
   parameter int   EDGE_CNT_W  = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic irq,
   input  logic claim_sel,
   input  logic complete_sel,
   output logic ip,
   output logic in_flight,
   output logic drop
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   fire;
   logic                   claim_hit;
   logic                   comp_hit;

   assign s         = sync_q[SYNC_STAGES-1];
   assign claim_hit = claim_sel & ip;
   assign comp_hit  = complete_sel & in_flight;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
   end

   generate
      if (IS_EDGE) begin : g_edge
         localparam logic [EDGE_CNT_W-1:0] CNT_MAX = {EDGE_CNT_W{1'b1}};
         logic                  s_d;
         logic                  rise;
         logic [EDGE_CNT_W-1:0] cnt;

         assign rise = s & ~s_d;
         assign fire = (cnt != '0) & ~in_flight;
         // A saturated counter absorbs the edge only if a fire frees a slot.
         assign drop = rise & (cnt == CNT_MAX) & ~fire;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               s_d <= 1'b0;
               cnt <= '0;
            end else begin
               s_d <= s;
               if (rise && !fire && !drop) cnt <= cnt + 1'b1;
               else if (fire && !rise)     cnt <= cnt - 1'b1;
            end
         end
      end else begin : g_level
         assign fire = s & ~in_flight;
         assign drop = 1'b0;
      end
   endgenerate

   // fire needs ~in_flight while claim/complete hits need ip/in_flight set,
   // so fire never competes with a clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ip        <= 1'b0;
         in_flight <= 1'b0;
      end else begin
         if (fire)                       ip <= 1'b1;
         else if (claim_hit || comp_hit) ip <= 1'b0;
         if (fire)          in_flight <= 1'b1;
         else if (comp_hit) in_flight <= 1'b0;
      end
   end
endmodule

module plic_gateway_array #(
   parameter int              NSRC        = 8,
   parameter int              SYNC_STAGES = 2,
   parameter logic [NSRC-1:0] EDGE_MASK   = {NSRC{1'b0}},
   parameter int              EDGE_CNT_W  = 2,
   parameter int              IDW         = $clog2(NSRC+1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_in,
   input  logic            claim_valid,
   input  logic [IDW-1:0]  claim_id,
   input  logic            complete_valid,
   input  logic [IDW-1:0]  complete_id,
   output logic [NSRC-1:0] ip,
   output logic [NSRC-1:0] in_flight,
   output logic            edge_drop
);
   logic [NSRC-1:0] claim_sel;
   logic [NSRC-1:0] complete_sel;
   logic [NSRC-1:0] drop_v;

   // ID 0 and IDs above NSRC match no source and fall through harmlessly.
   for (genvar i = 0; i < NSRC; i++) begin : g_src
      assign claim_sel[i]    = claim_valid    && (claim_id    == IDW'(i+1));
      assign complete_sel[i] = complete_valid && (complete_id == IDW'(i+1));

      plic_gateway_src #(
         .SYNC_STAGES (SYNC_STAGES),
         .IS_EDGE     (EDGE_MASK[i]),
         .EDGE_CNT_W  (EDGE_CNT_W)
      ) u_src (
         .clock        (clock),
         .reset        (reset),
         .irq          (irq_in[i]),
         .claim_sel    (claim_sel[i]),
         .complete_sel (complete_sel[i]),
         .ip           (ip[i]),
         .in_flight    (in_flight[i]),
         .drop         (drop_v[i])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) edge_drop <= 1'b0;
      else        edge_drop <= |drop_v;
   end
endmodule

// File: doc/plic_gateway_array.md
Name: plic_gateway_array

Overview:
- Upstream stage of the PLIC fan-in/priority-select logic. Converts raw, asynchronous device interrupt lines into per-source pending bits (ip) that drive the fan-in comparator.
- Implements the PLIC gateway protocol per source: synchroniser, level or edge capture, an in-flight lock, claim clears pending, complete releases the lock.
- Sources are numbered 1..NSRC. ID 0 is reserved and means "no interrupt". Bit i of every vector maps to source i+1.

Parameters:
- NSRC, 8, number of interrupt sources.
- SYNC_STAGES, 2, synchroniser flops per irq_in bit (>=2).
- EDGE_MASK, {NSRC{1'b0}}, bit i=1 makes source i+1 edge-triggered; 0 makes it level-triggered.
- EDGE_CNT_W, 2, width of the saturating pending-edge counter per edge source.
- IDW, $clog2(NSRC+1), width of claim/complete IDs (derived; do not override).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- irq_in  in  NSRC  raw device interrupt lines, asynchronous to clock.
- claim_valid  in  1  one-cycle claim strobe from hart claim logic.
- claim_id  in  IDW  ID being claimed.
- complete_valid  in  1  one-cycle completion strobe.
- complete_id  in  IDW  ID being completed.
- ip  out  NSRC  registered pending bits to the fan-in.
- in_flight  out  NSRC  registered gateway lock bits (claimed or pending, not yet completed).
- edge_drop  out  1  registered one-cycle pulse: an edge was lost because a counter was saturated.

Behaviour:
- Reset (reset==0, asynchronous): synchroniser flops, edge-detect history, counters, ip, in_flight and edge_drop all go to 0. Release takes effect on the next clock edge. A reset asserted mid-operation discards all pending, in-flight and counted state. Nothing is replayed.
- Sync: s[i] is irq_in[i] delayed by SYNC_STAGES flops. irq_in to earliest ip assertion = SYNC_STAGES+1 cycles.
- Fire condition per source, evaluated each cycle on current register values:
  - level: fire = s[i] & ~in_flight[i].
  - edge: fire = (cnt[i]!=0) & ~in_flight[i].
  - On fire: ip[i]<=1 and in_flight[i]<=1 next cycle.
- Edge capture:
  - rise[i] = s[i] & ~s_d[i], where s_d is s delayed by one cycle.
  - cnt next = cnt + rise - fire.
  - If rise arrives while cnt is at max (2^EDGE_CNT_W-1) and there is no simultaneous fire, the edge is dropped and edge_drop pulses the next cycle. edge_drop is the OR over all sources.
  - Level sources have no counter and never drop.
- Claim:
  - claim_valid with 1<=claim_id<=NSRC and ip[claim_id-1]==1 clears that ip bit next cycle. in_flight is unchanged.
  - ID 0, ID>NSRC, or a non-pending ID is ignored.
  - A claim cannot hit a source that fires in the same cycle, because ip is still 0 then. That claim is ignored and ip sets.
- Complete:
  - complete_valid with a valid ID and in_flight==1 clears in_flight next cycle. Otherwise it is ignored.
  - Completing while ip is still 1 (no claim yet) also clears ip.
  - Re-fire cannot occur earlier than the cycle after in_flight clears, so there is at least a 1-cycle gap in ip.
- Claim and complete of the same ID in the same cycle: both take effect, so ip=0 and in_flight=0 next cycle.
- Claim and complete of different IDs in the same cycle: independent.
- A level source dropping low while pending does not retract ip. The gateway latches the request until it is claimed.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- Level basic (NSRC=8, SYNC_STAGES=2): raise irq_in[2] at cycle 0 → ip=8'h04 and in_flight=8'h04 at cycle 3. Claim id 3 → ip=0, in_flight=8'h04. Complete id 3 with irq_in low → in_flight=0, and ip stays 0.
- Level held: keep irq_in[0] high through claim/complete of id 1 → in_flight clears at complete+1, ip and in_flight re-assert at complete+2.
- Edge counting (EDGE_MASK=8'h01, EDGE_CNT_W=2): 3 rising pulses on irq_in[0] before any claim → 3 successive fire/claim/complete rounds, then ip stays 0. No edge_drop.
- Edge saturation: 5 pulses with no service (first fires, leaving 3 counted) → edge_drop pulses once for the 5th edge. Exactly 4 total firings after full servicing.
- Illegal IDs: claim_id=0, claim_id=9, and complete of a non-in-flight ID → ip and in_flight unchanged. Same-cycle claim and complete of id 5 while pending → ip[4]=0 and in_flight[4]=0 next cycle.
- Reset mid-operation: ip=8'h05 and a counter at 2, assert reset asynchronously between clock edges → all outputs 0 immediately. After release with inputs low, no firing occurs.
